// File: rtl/countdown_sequencer.sv
// Run/pause/reload controller for the down-counter datapath.
// A single-clock prescaler produces the tick events that decrement the owned counter.
module countdown_sequencer #(
    parameter int unsigned DIV_WIDTH   = 24,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                   mainClock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] loadValue,
    input  logic                   autoReload,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   tick,
    output logic                   done,
    output logic                   running,
    output logic                   expired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } stateType;

    stateType               state;
    stateType               stateNext;
    logic [DIV_WIDTH-1:0]   prescaler;
    logic [DIV_WIDTH-1:0]   prescalerNext;
    logic [COUNT_WIDTH-1:0] reloadReg;
    logic [COUNT_WIDTH-1:0] reloadNext;
    logic [COUNT_WIDTH-1:0] countNext;
    logic                   tickNext;
    logic                   doneNext;
    logic                   prescalerWrap;

    assign prescalerWrap = &prescaler;

    // State register
    always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath registers; count and reload value power up at all ones
    always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) begin
            count     <= '1;
            reloadReg <= '1;
            prescaler <= '0;
            tick      <= 1'b0;
            done      <= 1'b0;
        end else begin
            count     <= countNext;
            reloadReg <= reloadNext;
            prescaler <= prescalerNext;
            tick      <= tickNext;
            done      <= doneNext;
        end
    end

    // Next-state and datapath update; command priority is load, start, pause, tick
    always_comb begin
        stateNext     = state;
        countNext     = count;
        reloadNext    = reloadReg;
        prescalerNext = prescaler;
        tickNext      = 1'b0;
        doneNext      = 1'b0;

        if (load) begin
            countNext     = loadValue;
            reloadNext    = loadValue;
            prescalerNext = '0;
            stateNext     = IDLE;
        end else if (start && (state != RUN)) begin
            stateNext = RUN;
            // Resuming from PAUSED keeps the partial period already counted
            if (state != PAUSED) begin
                prescalerNext = '0;
            end
            if (state == DONE) begin
                countNext = reloadReg;
            end
        end else if (pause && (state == RUN)) begin
            stateNext = PAUSED;
        end else if (state == RUN) begin
            prescalerNext = prescaler + DIV_WIDTH'(1);
            if (prescalerWrap) begin
                tickNext = 1'b1;
                if (count != '0) begin
                    countNext = count - COUNT_WIDTH'(1);
                end else begin
                    doneNext = 1'b1;
                    if (autoReload) begin
                        countNext = reloadReg;
                    end else begin
                        stateNext = DONE;
                    end
                end
            end
        end
    end

    // Status decoded from the state register
    always_comb begin
        running = 1'b0;
        expired = 1'b0;
        if (state == RUN) begin
            running = 1'b1;
        end
        if (state == DONE) begin
            expired = 1'b1;
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios plus random commands,
// checked against a per-edge behavioural model through a scoreboard.
module tb_countdown_sequencer;

    localparam int unsigned DW = 3;
    localparam int unsigned CW = 4;
    localparam int          P  = 8;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tk;
        logic       dn;
        logic       run;
        logic       ex;
    } snapT;

    logic          mainClock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] loadValue = '0;
    logic          autoReload = 1'b0;
    logic [CW-1:0] count;
    logic          tick;
    logic          done;
    logic          running;
    logic          expired;

    countdown_sequencer #(.DIV_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .mainClock (mainClock),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .load      (load),
        .loadValue (loadValue),
        .autoReload(autoReload),
        .count     (count),
        .tick      (tick),
        .done      (done),
        .running   (running),
        .expired   (expired)
    );

    always #5 mainClock = ~mainClock;

    snapT  expQ[$];
    snapT  tickQ[$];
    int    checks = 0;
    int    fails = 0;
    bit    endReq = 1'b0;
    bit    dirValid = 1'b0;
    snapT  dirExp;
    string dirName = "";

    int mMode, mCount, mReload, mPhase;
    bit mTick, mDone;

    function automatic string fmt(input snapT s);
        return $sformatf("cnt=%0d tick=%0b done=%0b run=%0b exp=%0b",
                         s.cnt, s.tk, s.dn, s.run, s.ex);
    endfunction

    // Reference model: counts RUN edges per period and applies the command rules
    initial begin : model
        forever begin
            @(posedge mainClock or negedge reset);
            if (!reset) begin
                mMode = M_IDLE; mCount = 15; mReload = 15; mPhase = 0;
                expQ.delete();
                tickQ.delete();
            end else begin
                mTick = 1'b0;
                mDone = 1'b0;
                if (load) begin
                    mCount = int'(loadValue); mReload = int'(loadValue);
                    mPhase = 0; mMode = M_IDLE;
                end else if (start && mMode != M_RUN) begin
                    if (mMode != M_PAUSED) mPhase = 0;
                    if (mMode == M_DONE) mCount = mReload;
                    mMode = M_RUN;
                end else if (pause && mMode == M_RUN) begin
                    mMode = M_PAUSED;
                end else if (mMode == M_RUN) begin
                    mPhase = mPhase + 1;
                    if (mPhase == P) begin
                        mPhase = 0;
                        mTick = 1'b1;
                        if (mCount > 0) begin
                            mCount = mCount - 1;
                        end else begin
                            mDone = 1'b1;
                            if (autoReload) mCount = mReload;
                            else mMode = M_DONE;
                        end
                    end
                end
                expQ.push_back('{cnt: 4'(mCount), tk: mTick, dn: mDone,
                                 run: (mMode == M_RUN), ex: (mMode == M_DONE)});
                if (mTick)
                    tickQ.push_back('{cnt: 4'(mCount), tk: 1'b1, dn: mDone,
                                      run: (mMode == M_RUN), ex: (mMode == M_DONE)});
            end
        end
    end

    // Monitor: owns all comparisons and the summary
    initial begin : monitor
        snapT e;
        snapT got;
        forever begin
            @(negedge mainClock or negedge reset);
            if (!reset) begin
                #1;
                got = {count, tick, done, running, expired};
                e   = '{cnt: 4'd15, tk: 1'b0, dn: 1'b0, run: 1'b0, ex: 1'b0};
                checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL reset_state: got %s, want %s", fmt(got), fmt(e));
                end
            end else begin
                got = {count, tick, done, running, expired};
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checks++;
                    if (got !== e) begin
                        fails++;
                        $display("FAIL cycle @%0t: got %s, want %s", $time, fmt(got), fmt(e));
                    end
                end
                if (tick === 1'b1) begin
                    checks++;
                    if (tickQ.size() == 0) begin
                        fails++;
                        $display("FAIL tick_event @%0t: got unexpected tick cnt=%0d, want no tick",
                                 $time, count);
                    end else begin
                        e = tickQ.pop_front();
                        if ({count, done} !== {e.cnt, e.dn}) begin
                            fails++;
                            $display("FAIL tick_event @%0t: got cnt=%0d done=%0b, want cnt=%0d done=%0b",
                                     $time, count, done, e.cnt, e.dn);
                        end
                    end
                end
                if (dirValid) begin
                    checks++;
                    if (got !== dirExp) begin
                        fails++;
                        $display("FAIL %s: got %s, want %s", dirName, fmt(got), fmt(dirExp));
                    end
                end
                if (endReq) begin
                    checks++;
                    if (tickQ.size() != 0) begin
                        fails++;
                        $display("FAIL pending_ticks: got %0d unmatched, want 0", tickQ.size());
                    end
                    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                    $finish;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mainClock);
            #1;
            dirValid = 1'b0;
        end
    endtask

    task automatic setIn(input logic s, input logic p, input logic l, input logic [3:0] lv);
        start = s; pause = p; load = l; loadValue = lv;
    endtask

    task automatic expectNow(input string name, input int c, input logic tk,
                             input logic dn, input logic run, input logic ex);
        dirName  = name;
        dirExp   = '{cnt: 4'(c), tk: tk, dn: dn, run: run, ex: ex};
        dirValid = 1'b1;
    endtask

    task automatic loadAndStart(input logic [3:0] lv);
        setIn(1'b0, 1'b0, 1'b1, lv); cyc(1);
        setIn(1'b1, 1'b0, 1'b0, 4'd0); cyc(1);
        setIn(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin : driver
        int r;
        repeat (3) @(posedge mainClock);
        #3 reset = 1'b1;
        cyc(50);
        expectNow("idle_after_reset", 15, 0, 0, 0, 0);

        // load 3, single shot
        autoReload = 1'b0;
        loadAndStart(4'd3);
        cyc(8);  expectNow("ld3_tick1", 2, 1, 0, 1, 0);
        cyc(8);  expectNow("ld3_tick2", 1, 1, 0, 1, 0);
        cyc(8);  expectNow("ld3_tick3", 0, 1, 0, 1, 0);
        cyc(8);  expectNow("ld3_done", 0, 1, 1, 0, 1);
        cyc(40); expectNow("ld3_quiet", 0, 0, 0, 0, 1);

        // load 2, auto reload
        autoReload = 1'b1;
        loadAndStart(4'd2);
        cyc(8);  expectNow("ar_tick1", 1, 1, 0, 1, 0);
        cyc(16); expectNow("ar_reload1", 2, 1, 1, 1, 0);
        cyc(24); expectNow("ar_reload2", 2, 1, 1, 1, 0);

        // load 5, pause over edges +5..+13, resume at +14
        autoReload = 1'b0;
        loadAndStart(4'd5);
        cyc(4);
        setIn(1'b0, 1'b1, 1'b0, 4'd0); cyc(9);
        expectNow("pause_hold", 5, 0, 0, 0, 0);
        setIn(1'b1, 1'b0, 1'b0, 4'd0); cyc(1);
        setIn(1'b0, 1'b0, 1'b0, 4'd0); cyc(4);
        expectNow("resume_tick", 4, 1, 0, 1, 0);
        // pause exactly on the wrap edge
        cyc(7);
        setIn(1'b0, 1'b1, 1'b0, 4'd0); cyc(1);
        expectNow("pause_on_wrap", 4, 0, 0, 0, 0);
        setIn(1'b0, 1'b0, 1'b0, 4'd0); cyc(3);
        setIn(1'b1, 1'b0, 1'b0, 4'd0); cyc(1);
        expectNow("resume_edge", 4, 0, 0, 1, 0);
        setIn(1'b0, 1'b0, 1'b0, 4'd0); cyc(1);
        expectNow("tick_after_resume", 3, 1, 0, 1, 0);

        // load 4, then load 9 on a tick edge
        loadAndStart(4'd4);
        cyc(8); expectNow("ld4_tick1", 3, 1, 0, 1, 0);
        cyc(7);
        setIn(1'b0, 1'b0, 1'b1, 4'd9); cyc(1);
        expectNow("load_on_tick", 9, 0, 0, 0, 0);
        setIn(1'b0, 1'b0, 1'b0, 4'd0);

        // asynchronous reset mid-period
        loadAndStart(4'd15);
        cyc(11);
        #2 reset = 1'b0;
        cyc(3);
        #2 reset = 1'b1;
        cyc(30);
        expectNow("idle_after_async_reset", 15, 0, 0, 0, 0);

        // random commands
        repeat (1500) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       setIn(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
            else if (r < 4)  setIn(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
            else if (r < 11) setIn(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            else if (r < 16) setIn(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
            else             setIn(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 63) == 0) autoReload = ~autoReload;
            cyc(1);
        end
        setIn(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(3);
        endReq = 1'b1;
    end

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Run/pause/reload controller for the 4-bit down-counter datapath. Replaces the derived slow clock with a single-clock prescaler that produces a one-cycle tick enable. Owns the counter register and sequences it through idle, run, pause and expire states under start/pause/load commands. Reports terminal count to downstream logic.

## Interface
- DIV_WIDTH, 24: prescaler width; tick period P = 2^DIV_WIDTH mainClock cycles.
- COUNT_WIDTH, 4: counter width.
- mainClock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled each edge; begins or resumes counting.
- pause  in  1  level, sampled each edge; freezes counting.
- load  in  1  level, sampled each edge; loads loadValue and returns to IDLE.
- loadValue  in  COUNT_WIDTH  start/reload value.
- autoReload  in  1  on expiry, reload and keep running instead of stopping.
- count  out  COUNT_WIDTH  current counter value, registered.
- tick  out  1  registered one-cycle pulse, high in the cycle the new count is first visible.
- done  out  1  registered one-cycle pulse on expiry.
- running  out  1  high in RUN; decoded from the state register.
- expired  out  1  high in DONE; decoded from the state register.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Internal registers: prescaler (DIV_WIDTH), reloadReg (COUNT_WIDTH).
- Reset (reset low, asynchronous): state=IDLE, count=all ones (15), reloadReg=all ones, prescaler=0, tick=0, done=0. The block stays in this state while reset is low.
- Command priority per edge: load > start > pause > tick.
- load (any state): count=reloadReg=loadValue, prescaler=0, state=IDLE. Any tick due on this edge is discarded.
- start:
  - From IDLE: state=RUN, prescaler=0.
  - From PAUSED: state=RUN, prescaler held.
  - From DONE: state=RUN, count=reloadReg, prescaler=0.
  - In RUN: ignored.
- pause: from RUN, state=PAUSED and prescaler holds. This includes the edge where prescaler is all ones; no tick occurs, and the tick fires on the first RUN edge after resume. Ignored in the other states.
- RUN, no command: prescaler increments and wraps at 2^DIV_WIDTH-1 → 0. On the wrap edge a tick event occurs:
  - count≠0: count=count-1, tick=1.
  - count=0 and autoReload=1: count=reloadReg, tick=1, done=1, stay in RUN.
  - count=0 and autoReload=0: state=DONE, count stays 0, tick=1, done=1.
- tick and done are 0 on every edge without a tick event. In IDLE, PAUSED and DONE, count and prescaler hold.
- Arithmetic is unsigned modulo 2^COUNT_WIDTH. Decrement never wraps, because the zero case is handled above.
- loadValue=0: the first tick after start expires immediately.

## Timing
- start at edge E0 (from IDLE): running=1 after E0; tick events occur at E0+k·P, k≥1.
- Starting value N, no pause: count=N-k after event k (k≤N). done occurs at event N+1, i.e. (N+1)·P cycles after E0.
- Pause/resume: total RUN cycles to each tick are preserved. Cycles spent in PAUSED add exactly to the latency.
- tick/done: high exactly one cycle, coincident with the updated count.
- Outputs change only on mainClock edges, except on reset assertion, which is asynchronous.

## Test plan
- Use DIV_WIDTH=3 (P=8) for all scenarios.
- Reset then idle: count=15, running=0, expired=0, tick=0 for 50 cycles.
- load 3, start, autoReload=0: ticks at +8,+16,+24 with count 2,1,0. At +32, done pulse with expired=1 and count=0. No further ticks for 40 cycles.
- load 2, autoReload=1, start: count sequence 1,0,2,1,0,2. done pulses at +24 and +48. running stays 1.
- load 5, start; pause at +5 for 10 cycles, then start: first tick at +18, count=4. Pause on the wrap edge: no tick, and the tick fires on the first edge after resume.
- load 4, start; at +16 assert load with loadValue=9 on a tick edge: count=9, state IDLE, tick=0.
- Run from 15; drop reset asynchronously mid-period: count=15 and running=0 immediately. After release, no tick until start.
